// File: rtl/qs_fifo_push_arb.sv
// qs_fifo_push_arb
// Packet-aware round-robin arbiter that shares a single qs_fifo write port
// between NUM_REQ valid/ready requesters. A granted beat is forwarded to the
// FIFO push port in the same cycle with its source index. Once the first beat
// of a multi-beat packet is accepted, the grant stays locked to that requester
// until its last beat is accepted.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   req_valid_i      per-requester beat valid
//   req_data_i       per-requester beat data, requester i at [i*DATA_W +: DATA_W]
//   req_last_i       per-requester last-beat flag (qualified by valid)
//   req_ready_o      per-requester beat accepted this cycle
//   full_i           FIFO full flag
//   push_o           FIFO push strobe
//   push_data_o      pushed beat data
//   push_src_o       index of the requester being pushed
//   push_last_o      last flag of the pushed beat
//   grant_o          one-hot current grant, 0 when none
//   busy_o           high while locked to a packet
module qs_fifo_push_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    localparam int SRC_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      full_i,
    output logic                      push_o,
    output logic [DATA_W-1:0]         push_data_o,
    output logic [SRC_W-1:0]          push_src_o,
    output logic                      push_last_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o
);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [SRC_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [SRC_W-1:0] lock_idx, lock_idx_nxt;

    logic [SRC_W-1:0] pick_idx;
    logic             pick_found;
    logic [SRC_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             accept;

    // base + off modulo NUM_REQ, valid for non-power-of-two NUM_REQ
    function automatic logic [SRC_W-1:0] rot_idx(input logic [SRC_W-1:0] base,
                                                 input int unsigned      off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= 32'(NUM_REQ)) s = s - 32'(NUM_REQ);
        return s[SRC_W-1:0];
    endfunction

    function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
        return (idx == SRC_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Rotating-priority search starting at rr_ptr
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && req_valid_i[rot_idx(rr_ptr, k)]) begin
                pick_found = 1'b1;
                pick_idx   = rot_idx(rr_ptr, k);
            end
        end
    end

    always_comb begin
        gnt_idx = pick_idx;
        gnt_any = pick_found;
        if (state == LOCK) begin
            gnt_idx = lock_idx;
            gnt_any = 1'b1;
        end
        if (reset) gnt_any = 1'b0;
    end

    // Output mux; everything collapses to zero when nothing is granted
    always_comb begin
        grant_o     = '0;
        push_data_o = '0;
        push_last_o = 1'b0;
        push_src_o  = '0;
        if (gnt_any) begin
            push_src_o = gnt_idx;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt_idx == SRC_W'(i)) begin
                    grant_o[i]  = 1'b1;
                    push_data_o = req_data_i[i*DATA_W +: DATA_W];
                    push_last_o = req_last_i[i];
                end
            end
        end
    end

    assign accept      = (|(grant_o & req_valid_i)) & ~full_i;
    assign push_o      = accept;
    assign req_ready_o = full_i ? '0 : grant_o;
    assign busy_o      = (state == LOCK) & ~reset;

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        lock_idx_nxt = lock_idx;
        if (accept) begin
            if (push_last_o) begin
                state_nxt  = ARB;
                rr_ptr_nxt = next_idx(gnt_idx);
            end else begin
                state_nxt    = LOCK;
                lock_idx_nxt = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            lock_idx <= lock_idx_nxt;
        end
    end

endmodule

// File: tb/tb_qs_fifo_push_arb.sv
module tb_qs_fifo_push_arb;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_last, req_ready, grant;
    logic [N*DW-1:0] req_data;
    logic            full, push, push_last, busy;
    logic [DW-1:0]   push_data;
    logic [1:0]      push_src;

    int n_cmp = 0;
    int n_bad = 0;

    qs_fifo_push_arb #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .full_i      (full),
        .push_o      (push),
        .push_data_o (push_data),
        .push_src_o  (push_src),
        .push_last_o (push_last),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [DW-1:0] d, input logic l);
        req_valid[i]         = v;
        req_data[i*DW +: DW] = d;
        req_last[i]          = l;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        full      = 1'b0;
    endtask

    task automatic do_reset();
        clear_all();
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '1;
        req_last  = '1;
        req_data  = 32'hDEADBEEF;
        full      = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({grant, req_ready, push, busy} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got grant=%b ready=%b push=%b busy=%b want all 0",
                     grant, req_ready, push, busy);
        end
        next_cyc();
        reset = 1'b0;
        clear_all();
    endtask

    // Requester 2 sends a 3-beat packet, then all four single beats show rr_ptr=3
    task automatic test_packet_lock();
        int exp;
        do_reset();
        for (int b = 0; b < 3; b++) begin
            set_req(2, 1'b1, 8'hA0 + 8'(b), b == 2);
            @(negedge clk);
            n_cmp++;
            if ({push, push_src, push_data, grant, busy} !== {1'b1, 2'd2, 8'hA0 + 8'(b), 4'b0100, b > 0}) begin
                n_bad++;
                $display("FAIL pkt_beat%0d: got push=%b src=%0d data=%h grant=%b busy=%b want 1 2 %h 0100 %b",
                         b, push, push_src, push_data, grant, busy, 8'hA0 + 8'(b), b > 0);
            end
            next_cyc();
        end
        set_req(2, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'h10 + 8'(i), 1'b1);
        for (int k = 0; k < N; k++) begin
            exp = (3 + k) % N;
            @(negedge clk);
            n_cmp++;
            if ({grant, push, busy} !== {4'(1 << exp), 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL rr_after_pkt%0d: got grant=%b push=%b busy=%b want grant=%b push=1 busy=0",
                         k, grant, push, busy, 4'(1 << exp));
            end
            next_cyc();
            set_req(exp, 1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        set_req(0, 1'b1, 8'h20, 1'b1);
        set_req(1, 1'b1, 8'h21, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({push, push_src, push_data} !== {1'b1, 2'(k % 2), 8'h20 + 8'(k % 2)}) begin
                n_bad++;
                $display("FAIL fair%0d: got push=%b src=%0d data=%h want 1 %0d %h",
                         k, push, push_src, push_data, k % 2, 8'h20 + 8'(k % 2));
            end
            next_cyc();
            if (k >= 4) set_req(k % 2, 1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic test_lock_holds();
        do_reset();
        set_req(1, 1'b1, 8'h30, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({grant, push, push_data, push_last, busy} !== {4'b0010, 1'b1, 8'h30 + 8'(c), c == 2, c > 0}) begin
                n_bad++;
                $display("FAIL lock%0d: got grant=%b push=%b data=%h last=%b busy=%b want 0010 1 %h %b %b",
                         c, grant, push, push_data, push_last, busy, 8'h30 + 8'(c), c == 2, c > 0);
            end
            next_cyc();
            if (c == 0) begin
                set_req(0, 1'b1, 8'h40, 1'b1);
                set_req(3, 1'b1, 8'h43, 1'b1);
            end
            set_req(1, c < 2, 8'h31 + 8'(c), c == 1);
        end
        @(negedge clk);
        n_cmp++;
        if ({grant, push_src, push_data, busy} !== {4'b1000, 2'd3, 8'h43, 1'b0}) begin
            n_bad++;
            $display("FAIL lock_release: got grant=%b src=%0d data=%h busy=%b want 1000 3 43 0",
                     grant, push_src, push_data, busy);
        end
        next_cyc();
        set_req(3, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({grant, push_data} !== {4'b0001, 8'h40}) begin
            n_bad++;
            $display("FAIL lock_then0: got grant=%b data=%h want 0001 40", grant, push_data);
        end
        next_cyc();
        set_req(0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_full_stall();
        logic [5:0] full_pat = 6'b000110;  // bit c = full during cycle c
        int b = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            full = full_pat[c];
            set_req(2, 1'b1, 8'h50 + 8'(b), b == 3);
            if (c == 1) set_req(0, 1'b1, 8'h60, 1'b1);
            @(negedge clk);
            n_cmp++;
            if (full) begin
                if ({push, req_ready, grant, busy} !== {1'b0, 4'b0000, 4'b0100, 1'b1}) begin
                    n_bad++;
                    $display("FAIL full_stall%0d: got push=%b ready=%b grant=%b busy=%b want 0 0000 0100 1",
                             c, push, req_ready, grant, busy);
                end
            end else begin
                if ({push, push_data, grant, req_ready} !== {1'b1, 8'h50 + 8'(b), 4'b0100, 4'b0100}) begin
                    n_bad++;
                    $display("FAIL full_burst%0d: got push=%b data=%h grant=%b ready=%b want 1 %h 0100 0100",
                             c, push, push_data, grant, req_ready, 8'h50 + 8'(b));
                end
            end
            next_cyc();
            if (!full) b++;
        end
        full = 1'b0;
        set_req(2, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({b == 4, grant, push_data, busy} !== {1'b1, 4'b0001, 8'h60, 1'b0}) begin
            n_bad++;
            $display("FAIL full_after: got beats=%0d grant=%b data=%h busy=%b want 4 0001 60 0",
                     b, grant, push_data, busy);
        end
        next_cyc();
        set_req(0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        set_req(3, 1'b1, 8'h70, 1'b0);
        next_cyc();
        set_req(3, 1'b1, 8'h71, 1'b0);
        next_cyc();
        set_req(3, 1'b1, 8'h72, 1'b0);
        set_req(0, 1'b1, 8'h80, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({push, grant, req_ready, busy} !== 10'b0) begin
            n_bad++;
            $display("FAIL rst_mid_during: got push=%b grant=%b ready=%b busy=%b want all 0",
                     push, grant, req_ready, busy);
        end
        next_cyc();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({grant, push_src, push_data, busy} !== {4'b0001, 2'd0, 8'h80, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_mid_after: got grant=%b src=%0d data=%h busy=%b want 0001 0 80 0",
                     grant, push_src, push_data, busy);
        end
        next_cyc();
        set_req(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({grant, push_data, busy} !== {4'b1000, 8'h72, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_mid_resume: got grant=%b data=%h busy=%b want 1000 72 0",
                     grant, push_data, busy);
        end
        next_cyc();
        set_req(3, 1'b1, 8'h73, 1'b1);
        next_cyc();
        set_req(3, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_bubble();
        logic [5:0] v2 = 6'b110011;  // bit c = requester 2 valid during cycle c
        int b = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_req(2, v2[c], v2[c] ? 8'h90 + 8'(b) : 8'h00, v2[c] && b == 3);
            if (c == 1) set_req(0, 1'b1, 8'hA5, 1'b1);
            @(negedge clk);
            n_cmp++;
            if ({push, push_data, grant, req_ready} !==
                {v2[c], v2[c] ? 8'h90 + 8'(b) : 8'h00, 4'b0100, 4'b0100}) begin
                n_bad++;
                $display("FAIL bubble%0d: got push=%b data=%h grant=%b ready=%b want %b %h 0100 0100",
                         c, push, push_data, grant, req_ready, v2[c], v2[c] ? 8'h90 + 8'(b) : 8'h00);
            end
            next_cyc();
            if (v2[c]) b++;
        end
        set_req(2, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({grant, push, push_src, push_data} !== {4'b0001, 1'b1, 2'd0, 8'hA5}) begin
            n_bad++;
            $display("FAIL bubble_after: got grant=%b push=%b src=%0d data=%h want 0001 1 0 a5",
                     grant, push, push_src, push_data);
        end
        next_cyc();
        set_req(0, 1'b0, 8'h00, 1'b0);
    endtask

    // Reference: priority search with modulo arithmetic over a packet-level model
    bit m_lock;
    int m_idx, m_rr;

    function automatic int model_pick(input logic [N-1:0] v);
        if (m_lock) return m_idx;
        for (int k = 0; k < N; k++)
            if (v[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    task automatic test_random();
        bit              offer[N];
        int              rem[N];
        logic [DW-1:0]   cd[N];
        int              e;
        logic [N-1:0]    eg, er;
        logic            ep, eb;
        do_reset();
        m_lock = 0;
        m_rr   = 0;
        for (int i = 0; i < N; i++) begin
            offer[i] = 0;
            rem[i]   = 0;
            cd[i]    = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!offer[i] && $urandom_range(0, 2) != 0) begin
                    if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
                    offer[i] = 1;
                    cd[i]    = 8'($urandom);
                end
                set_req(i, offer[i], offer[i] ? cd[i] : 8'h00, offer[i] && rem[i] == 1);
            end
            full  = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 199) == 0);
            e  = reset ? -1 : model_pick(req_valid);
            eg = (e >= 0) ? 4'(1 << e) : 4'b0;
            ep = (e >= 0) && req_valid[e] && !full;
            er = full ? 4'b0 : eg;
            eb = m_lock && !reset;
            @(negedge clk);
            n_cmp++;
            if ({grant, req_ready, push, busy} !== {eg, er, ep, eb}) begin
                n_bad++;
                $display("FAIL rand_ctrl cyc=%0d: got g=%b r=%b p=%b b=%b want g=%b r=%b p=%b b=%b",
                         cyc, grant, req_ready, push, busy, eg, er, ep, eb);
            end
            if (ep) begin
                n_cmp++;
                if ({push_src, push_data, push_last} !== {2'(e), cd[e], rem[e] == 1}) begin
                    n_bad++;
                    $display("FAIL rand_beat cyc=%0d: got src=%0d data=%h last=%b want %0d %h %b",
                             cyc, push_src, push_data, push_last, e, cd[e], rem[e] == 1);
                end
            end else if (eg == 4'b0) begin
                n_cmp++;
                if ({push_src, push_data, push_last} !== 11'b0) begin
                    n_bad++;
                    $display("FAIL rand_idle cyc=%0d: got src=%0d data=%h last=%b want 0 00 0",
                             cyc, push_src, push_data, push_last);
                end
            end
            next_cyc();
            if (reset) begin
                m_lock = 0;
                m_rr   = 0;
            end else if (ep) begin
                offer[e] = 0;
                rem[e]--;
                if (rem[e] == 0) begin
                    m_lock = 0;
                    m_rr   = (e + 1) % N;
                end else begin
                    m_lock = 1;
                    m_idx  = e;
                end
            end
            reset = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        clear_all();
        test_reset();
        test_packet_lock();
        test_fairness();
        test_lock_holds();
        test_full_stall();
        test_reset_mid_packet();
        test_bubble();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
